// File: rtl/mem_arbiter.sv
// Arbiter sharing one backing-memory port between I-cache refills and D-cache refills/write-throughs.
// Optional MEMARB_PERF_EN adds grant and stall performance counters.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_W     = 512,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              i_done,
    output logic              d_done,
    output logic [LINE_W-1:0] resp_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata
`ifdef MEMARB_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic {OWN_D, OWN_I} owner_e;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [7:0]        starve_q, starve_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] resp_q, resp_d;
    logic              grant_i, grant_d;
    logic              i_in_service;

    // I beats D on a tie only once it has waited STARVE_MAX cycles.
    always_comb begin
        grant_i = (state_q == IDLE) && i_req && (!d_req || (starve_q >= STARVE_LIM));
        grant_d = (state_q == IDLE) && d_req && !grant_i;
    end

    // Cycles where I's own transaction is in flight are not waiting cycles.
    assign i_in_service = (state_q != IDLE) && (owner_q == OWN_I);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        resp_d   = resp_q;
        starve_d = starve_q;

        if (grant_i) begin
            starve_d = '0;
        end else if (i_req && !i_in_service && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 8'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = BUSY;
                    owner_d = OWN_I;
                    we_d    = 1'b0;
                    addr_d  = i_addr;
                end else if (grant_d) begin
                    state_d = BUSY;
                    owner_d = OWN_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d = DONE;
                    if (!we_q) begin
                        resp_d = mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_D;
            starve_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            resp_q   <= resp_d;
        end
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign resp_data = resp_q;
    assign i_done    = (state_q == DONE) && (owner_q == OWN_I);
    assign d_done    = (state_q == DONE) && (owner_q == OWN_D);

`ifdef MEMARB_PERF_EN
    logic [31:0] perf_i_q, perf_d_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_i_q     <= '0;
            perf_d_q     <= '0;
            perf_stall_q <= '0;
        end else begin
            if (grant_i) begin
                perf_i_q <= perf_i_q + 32'd1;
            end
            if (grant_d) begin
                perf_d_q <= perf_d_q + 32'd1;
            end
            if (state_q == BUSY) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_i_grants     = perf_i_q;
    assign perf_d_grants     = perf_d_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_MAX=2 to exercise starvation override).
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned WORD_W = 32;

    logic              clk;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              i_done;
    logic              d_done;
    logic [LINE_W-1:0] resp_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;
`ifdef MEMARB_PERF_EN
    logic [31:0]       perf_i_grants;
    logic [31:0]       perf_d_grants;
    logic [31:0]       perf_stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [LINE_W-1:0] pat_a;
    logic [LINE_W-1:0] pat_b;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .LINE_W    (LINE_W),
        .WORD_W    (WORD_W),
        .STARVE_MAX(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .i_done   (i_done),
        .d_done   (d_done),
        .resp_data(resp_data),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
`ifdef MEMARB_PERF_EN
        ,
        .perf_i_grants    (perf_i_grants),
        .perf_d_grants    (perf_d_grants),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int bad;
        pat_a = {16{32'hCAFE_0001}};
        pat_b = {16{32'h1234_5678}};

        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_mem_req", LINE_W'(mem_req), '0);
        chk("rst_done", LINE_W'({i_done, d_done}), '0);
        chk("rst_mem_addr", LINE_W'(mem_addr), '0);
        chk("rst_resp", resp_data, '0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Single I refill: request cycle 0, ready cycle 3, done cycle 4
        i_req = 1'b1; i_addr = 32'h400;
        tick();
        chk("i1_req_c1", LINE_W'(mem_req), LINE_W'(1));
        chk("i1_addr_c1", LINE_W'(mem_addr), LINE_W'(32'h400));
        chk("i1_we_c1", LINE_W'(mem_we), '0);
        i_addr = 32'h999;
        tick();
        chk("i1_addr_c2", LINE_W'(mem_addr), LINE_W'(32'h400));
        chk("i1_done_c2", LINE_W'(i_done), '0);
        tick();
        chk("i1_req_c3", LINE_W'(mem_req), LINE_W'(1));
        mem_ready = 1'b1; mem_rdata = pat_a;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        chk("i1_done_c4", LINE_W'({i_done, d_done}), LINE_W'(2'b10));
        chk("i1_req_c4", LINE_W'(mem_req), '0);
        chk("i1_resp", resp_data, pat_a);
        i_req = 1'b0;
        tick();
        chk("i1_done_c5", LINE_W'({i_done, d_done}), '0);

        // D write-through with minimum latency
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF;
        tick();
        chk("dw_req", LINE_W'(mem_req), LINE_W'(1));
        chk("dw_we", LINE_W'(mem_we), LINE_W'(1));
        chk("dw_addr", LINE_W'(mem_addr), LINE_W'(32'h80));
        chk("dw_wdata", LINE_W'(mem_wdata), LINE_W'(32'hDEADBEEF));
        mem_ready = 1'b1; mem_rdata = pat_b;
        d_wdata = 32'h0;
        tick();
        mem_ready = 1'b0;
        chk("dw_done", LINE_W'({i_done, d_done}), LINE_W'(2'b01));
        chk("dw_resp_kept", resp_data, pat_a);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("dw_done_once", LINE_W'({i_done, d_done}), '0);

        // Reset mid-BUSY
        i_req = 1'b1; i_addr = 32'h700;
        tick();
        chk("rb_req", LINE_W'(mem_req), LINE_W'(1));
        i_req = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rb_req_async", LINE_W'(mem_req), '0);
        chk("rb_addr_async", LINE_W'(mem_addr), '0);
        chk("rb_resp_async", resp_data, '0);
        tick();
        rst = 1'b1;
        mem_ready = 1'b1; mem_rdata = pat_b;
        tick();
        chk("rb_ready_ign_req", LINE_W'(mem_req), '0);
        chk("rb_ready_ign_done", LINE_W'({i_done, d_done}), '0);
        tick();
        chk("rb_ready_ign_done2", LINE_W'({i_done, d_done}), '0);
        chk("rb_ready_ign_resp", resp_data, '0);
        mem_ready = 1'b0; mem_rdata = '0;

        // Simultaneous requests: D first, I in IDLE after d_done
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        tick();
        chk("tie_d_addr", LINE_W'(mem_addr), LINE_W'(32'h200));
        chk("tie_d_we", LINE_W'(mem_we), '0);
        mem_ready = 1'b1; mem_rdata = pat_b;
        tick();
        mem_ready = 1'b0;
        chk("tie_d_done", LINE_W'({i_done, d_done}), LINE_W'(2'b01));
        chk("tie_d_resp", resp_data, pat_b);
        d_req = 1'b0;
        tick();
        chk("tie_idle_req", LINE_W'(mem_req), '0);
        chk("tie_idle_done", LINE_W'({i_done, d_done}), '0);
        tick();
        chk("tie_i_addr", LINE_W'(mem_addr), LINE_W'(32'h100));
        mem_ready = 1'b1; mem_rdata = pat_a;
        tick();
        mem_ready = 1'b0;
        chk("tie_i_done", LINE_W'({i_done, d_done}), LINE_W'(2'b10));
        chk("tie_i_resp", resp_data, pat_a);
        i_req = 1'b0;
        tick();
        chk("tie_end_done", LINE_W'({i_done, d_done}), '0);

        // Starvation: D keeps requesting, I overrides after 2 waiting cycles
        i_req = 1'b1; i_addr = 32'h500;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        tick();
        chk("st_d1_addr", LINE_W'(mem_addr), LINE_W'(32'h300));
        mem_ready = 1'b1; mem_rdata = pat_b;
        tick();
        mem_ready = 1'b0;
        chk("st_d1_done", LINE_W'({i_done, d_done}), LINE_W'(2'b01));
        d_addr = 32'h340;
        tick();
        chk("st_idle_req", LINE_W'(mem_req), '0);
        tick();
        chk("st_i_wins", LINE_W'(mem_addr), LINE_W'(32'h500));
        mem_ready = 1'b1; mem_rdata = pat_a;
        tick();
        mem_ready = 1'b0;
        chk("st_i_done", LINE_W'({i_done, d_done}), LINE_W'(2'b10));
        i_req = 1'b0;
        tick();
        tick();
        chk("st_d2_addr", LINE_W'(mem_addr), LINE_W'(32'h340));
        mem_ready = 1'b1; mem_rdata = pat_b;
        tick();
        mem_ready = 1'b0;
        chk("st_d2_done", LINE_W'({i_done, d_done}), LINE_W'(2'b01));
        d_req = 1'b0;
        tick();

        // mem_ready stuck low for 100 cycles; D drops its request mid-BUSY
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        tick();
        d_req = 1'b0; d_addr = 32'h0;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (mem_req !== 1'b1 || mem_addr !== 32'h600 || i_done !== 1'b0 || d_done !== 1'b0) bad++;
            if (c != 99) tick();
        end
        chk("stuck_bad_cycles", LINE_W'(bad), '0);
        mem_ready = 1'b1; mem_rdata = pat_a;
        tick();
        mem_ready = 1'b0;
        chk("stuck_done", LINE_W'({i_done, d_done}), LINE_W'(2'b01));
        chk("stuck_resp", resp_data, pat_a);
        tick();
        chk("stuck_after", LINE_W'({mem_req, i_done, d_done}), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
